// File: rtl/cpu_bus_pkg.sv
// Shared ALU memory-bus definitions: MemIO encodings, controller FSM states and bus defaults.
package cpu_bus_pkg;

    localparam int unsigned DATA_W_DEFAULT = 32;

    localparam logic [1:0] MEMIO_NOP = 2'b00;
    localparam logic [1:0] MEMIO_RD  = 2'b01;
    localparam logic [1:0] MEMIO_WR  = 2'b10;
    localparam logic [1:0] MEMIO_GPR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } mc_state_e;

endpackage

// File: rtl/sp_ram.sv
// Single-port synchronous RAM with registered read data; the array itself is never reset.
module sp_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/memory_controller.sv
// Memory-side responder for the ALU bus: captures one read/write command, waits, accesses RAM,
// then presents read data for one cycle with a valid pulse.
module memory_controller
    import cpu_bus_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEFAULT,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mem_io,
    input  logic [31:0]       alu_addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_oe,
    output logic              valid_mem_data,
    output logic              busy,
    output logic              addr_err,
    output logic              req_drop
);

    localparam int unsigned CNT_W = 4;

    mc_state_e         state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              wr_q;
    logic              addr_ok_q;
    logic [ADDR_W-1:0] idx_q;
    logic [DATA_W-1:0] wdata_q;

    logic              cmd_valid;
    logic              in_range;
    logic              ram_we;
    logic [DATA_W-1:0] ram_dout;

    assign cmd_valid = (mem_io == MEMIO_RD) || (mem_io == MEMIO_WR);
    assign in_range  = (alu_addr[31:ADDR_W] == '0);
    // Out-of-range writes still walk through ACCESS but never reach the array.
    assign ram_we    = (state_q == ST_ACCESS) && wr_q && addr_ok_q;

    sp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (idx_q),
        .din  (wdata_q),
        .dout (ram_dout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            wr_q           <= 1'b0;
            addr_ok_q      <= 1'b0;
            idx_q          <= '0;
            wdata_q        <= '0;
            rdata          <= '0;
            rdata_oe       <= 1'b0;
            valid_mem_data <= 1'b0;
            busy           <= 1'b0;
            addr_err       <= 1'b0;
            req_drop       <= 1'b0;
        end else begin
            rdata          <= '0;
            rdata_oe       <= 1'b0;
            valid_mem_data <= 1'b0;
            addr_err       <= 1'b0;
            req_drop       <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    busy <= cmd_valid;
                    if (cmd_valid) begin
                        wr_q      <= (mem_io == MEMIO_WR);
                        addr_ok_q <= in_range;
                        idx_q     <= alu_addr[ADDR_W-1:0];
                        wdata_q   <= wdata;
                        cnt_q     <= CNT_W'(WAIT_STATES);
                        addr_err  <= !in_range;
                        state_q   <= (WAIT_STATES != 0) ? ST_WAIT : ST_ACCESS;
                    end
                end
                ST_WAIT: begin
                    req_drop <= cmd_valid;
                    if (cnt_q == CNT_W'(1)) begin
                        cnt_q   <= '0;
                        state_q <= ST_ACCESS;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_ACCESS: begin
                    req_drop <= cmd_valid;
                    state_q  <= ST_DONE;
                end
                ST_DONE: begin
                    // Read data is driven for exactly the cycle after leaving DONE; busy holds through it.
                    req_drop <= cmd_valid;
                    state_q  <= ST_IDLE;
                    if (!wr_q) begin
                        rdata          <= addr_ok_q ? ram_dout : '0;
                        rdata_oe       <= 1'b1;
                        valid_mem_data <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_controller.sv
// Directed self-checking bench for memory_controller with WAIT_STATES=2 and WAIT_STATES=0 instances.
module tb_memory_controller;
    import cpu_bus_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [1:0]  mem_io;
    logic [31:0] alu_addr;
    logic [31:0] wdata;

    logic [31:0] rdata2, rdata0;
    logic        oe2, oe0, valid2, valid0, busy2, busy0, err2, err0, drop2, drop0;

    logic        sel;
    logic [31:0] o_rdata;
    logic        o_oe, o_valid, o_busy, o_err, o_drop;

    int checks   = 0;
    int failures = 0;

    memory_controller #(.DATA_W(32), .ADDR_W(10), .WAIT_STATES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .mem_io(mem_io), .alu_addr(alu_addr), .wdata(wdata),
        .rdata(rdata2), .rdata_oe(oe2), .valid_mem_data(valid2), .busy(busy2),
        .addr_err(err2), .req_drop(drop2)
    );

    memory_controller #(.DATA_W(32), .ADDR_W(10), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .mem_io(mem_io), .alu_addr(alu_addr), .wdata(wdata),
        .rdata(rdata0), .rdata_oe(oe0), .valid_mem_data(valid0), .busy(busy0),
        .addr_err(err0), .req_drop(drop0)
    );

    always_comb begin
        o_rdata = sel ? rdata0 : rdata2;
        o_oe    = sel ? oe0    : oe2;
        o_valid = sel ? valid0 : valid2;
        o_busy  = sel ? busy0  : busy2;
        o_err   = sel ? err0   : err2;
        o_drop  = sel ? drop0  : drop2;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check1({tag, "_busy"}, o_busy, 1'b0);
        check1({tag, "_valid"}, o_valid, 1'b0);
        check1({tag, "_oe"}, o_oe, 1'b0);
        check1({tag, "_err"}, o_err, 1'b0);
        check1({tag, "_drop"}, o_drop, 1'b0);
        check32({tag, "_rdata"}, o_rdata, 32'h0);
    endtask

    // Issues one command at the next edge (E0) and checks every cycle through E(W+2).
    task automatic txn(input string tag, input logic [1:0] cmd, input logic [31:0] addr,
                       input logic [31:0] data, input logic exp_err,
                       input logic exp_valid, input logic [31:0] exp_rdata);
        int w;
        w        = sel ? 0 : 2;
        mem_io   = cmd;
        alu_addr = addr;
        wdata    = data;
        tick();
        mem_io   = MEMIO_NOP;
        alu_addr = ~addr;
        wdata    = ~data;
        check1({tag, "_busy_e0"}, o_busy, 1'b1);
        check1({tag, "_err_e0"}, o_err, exp_err);
        for (int k = 1; k <= w + 1; k++) begin
            tick();
            check1({tag, "_busy_mid"}, o_busy, 1'b1);
            check1({tag, "_valid_mid"}, o_valid, 1'b0);
            check1({tag, "_oe_mid"}, o_oe, 1'b0);
            check1({tag, "_err_mid"}, o_err, 1'b0);
        end
        tick();
        check1({tag, "_busy_last"}, o_busy, 1'b1);
        check1({tag, "_valid_last"}, o_valid, exp_valid);
        check1({tag, "_oe_last"}, o_oe, exp_valid);
        check32({tag, "_rdata_last"}, o_rdata, exp_rdata);
    endtask

    initial begin
        sel      = 1'b0;
        rst_n    = 1'b0;
        mem_io   = MEMIO_NOP;
        alu_addr = 32'h0;
        wdata    = 32'h0;

        // Reset state
        tick();
        tick();
        check_quiet("reset");
        rst_n = 1'b1;
        tick();
        check_quiet("post_reset");

        // Write then back-to-back read with two wait states
        txn("wr10", MEMIO_WR, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
        txn("rd10", MEMIO_RD, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
        tick();
        check_quiet("after_rd10");

        // Reserved/idle command codes do nothing
        for (int i = 0; i < 10; i++) begin
            mem_io = (i % 2 == 0) ? MEMIO_GPR : MEMIO_NOP;
            alu_addr = 32'h20 + 32'(i);
            tick();
            check_quiet("ignored");
        end
        mem_io = MEMIO_NOP;

        // Out-of-range accesses
        txn("wr0", MEMIO_WR, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0);
        txn("oor_rd", MEMIO_RD, 32'h400, 32'h0, 1'b1, 1'b1, 32'h0);
        txn("oor_wr", MEMIO_WR, 32'h400, 32'h55, 1'b1, 1'b0, 32'h0);
        txn("oor_hi", MEMIO_RD, 32'h8000_0010, 32'h0, 1'b1, 1'b1, 32'h0);
        txn("rd0", MEMIO_RD, 32'h0, 32'h0, 1'b0, 1'b1, 32'hA5A5A5A5);

        // Command arriving while busy is dropped
        txn("wr5", MEMIO_WR, 32'h5, 32'h1111_1111, 1'b0, 1'b0, 32'h0);
        mem_io   = MEMIO_RD;
        alu_addr = 32'h5;
        tick();
        mem_io   = MEMIO_WR;
        alu_addr = 32'h5;
        wdata    = 32'h2222_2222;
        tick();
        mem_io   = MEMIO_NOP;
        check1("drop_pulse", o_drop, 1'b1);
        tick();
        check1("drop_clear", o_drop, 1'b0);
        tick();
        check1("drop_no_valid_e3", o_valid, 1'b0);
        tick();
        check1("drop_valid_e4", o_valid, 1'b1);
        check32("drop_rdata_e4", o_rdata, 32'h1111_1111);
        txn("rd5", MEMIO_RD, 32'h5, 32'h0, 1'b0, 1'b1, 32'h1111_1111);

        // Reset aborts a read in WAIT
        txn("wr7", MEMIO_WR, 32'h7, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0);
        mem_io   = MEMIO_RD;
        alu_addr = 32'h7;
        tick();
        mem_io   = MEMIO_NOP;
        tick();
        check1("rst_pre_busy", o_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_quiet("rst_mid");
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check1("rst_no_valid", o_valid, 1'b0);
            check1("rst_no_busy", o_busy, 1'b0);
        end
        txn("rd7", MEMIO_RD, 32'h7, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D);
        tick();

        // Zero wait states
        sel = 1'b1;
        tick();
        check_quiet("ws0_idle");
        txn("ws0_wr3", MEMIO_WR, 32'h3, 32'h12345678, 1'b0, 1'b0, 32'h0);
        txn("ws0_rd3", MEMIO_RD, 32'h3, 32'h0, 1'b0, 1'b1, 32'h12345678);
        tick();
        check_quiet("ws0_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_controller.md
Name: memory_controller

Overview:
- Memory-side responder for the ALU memory bus (MemIO / ALUAddr / DataIO / ValidMemData).
- Accepts single-word read and write commands issued by the ALU (PUSH, POP, ST, STI) and serves them from an on-chip word-addressed RAM after a configurable number of wait states.
- Returns read data with a one-cycle ValidMemData pulse.
- Sits between the ALU and data memory. The top level resolves the tri-state DataIO into wdata (ALU to memory) and rdata/rdata_oe (memory to ALU).

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 10, word-address bits used; RAM depth = 2**ADDR_W words.
- WAIT_STATES, 2, extra cycles inserted before RAM access; legal range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_io  in  2  command from ALU MemIO: 00 NOP, 01 read, 10 write, 11 GPR writeback (ignored here).
- alu_addr  in  32  word address from ALU ALUAddr.
- wdata  in  DATA_W  write data (DataIO driven by ALU).
- rdata  out  DATA_W  read data toward DataIO.
- rdata_oe  out  1  top level drives DataIO from rdata while high.
- valid_mem_data  out  1  read data valid, one-cycle pulse (ALU ValidMemData).
- busy  out  1  command in progress; new commands are not accepted.
- addr_err  out  1  one-cycle pulse: captured address out of range.
- req_drop  out  1  one-cycle pulse: read/write command arrived while busy.

Behaviour:
- Reset (async assert, sync release): state IDLE; rdata=0, rdata_oe=0, valid_mem_data=0, busy=0, addr_err=0, req_drop=0; wait counter=0. RAM contents are not reset.
- FSM states: IDLE, WAIT, ACCESS, DONE.
- IDLE:
  - mem_io=01 or 10 at rising edge E0: capture mem_io, alu_addr and wdata; load counter=WAIT_STATES.
  - Next state is WAIT if WAIT_STATES>0, else ACCESS. busy goes high after E0.
  - mem_io=00 or 11: no action.
- WAIT: counter decrements each edge; go to ACCESS on the edge where counter reaches 1.
- ACCESS (one cycle):
  - Read: RAM read is synchronous and registers the data.
  - Write: RAM written with the captured wdata on the leaving edge.
  - Always go to DONE.
- DONE (one cycle):
  - Read: rdata = captured word, rdata_oe=1, valid_mem_data=1.
  - Write: no pulse.
  - Go to IDLE; busy=0 after the leaving edge.
- Timing: valid_mem_data is high for exactly the cycle after edge E(WAIT_STATES+2). busy stays high through that cycle. The earliest next accept is edge E(WAIT_STATES+3).
- rdata returns to 0 and rdata_oe to 0 outside DONE. The bus is never driven in any other state.
- Address range:
  - In range iff alu_addr[31:ADDR_W]==0; the RAM index is alu_addr[ADDR_W-1:0].
  - Out of range: addr_err pulses in the cycle after E0.
  - The command still runs its full timing. A read returns 0 with a normal valid pulse; a write is discarded.
- A read or write command seen while busy (states WAIT/ACCESS/DONE) is discarded. req_drop pulses the next cycle and the in-flight command is unaffected.
- Captured command/address/data hold for the whole transaction. Input changes after E0 have no effect.
- Reset mid-transaction aborts immediately and all outputs clear. A write in ACCESS when reset asserts is not guaranteed to commit.
- WAIT_STATES=0 skips WAIT entirely (IDLE to ACCESS).

Decomposition:
- Shared package cpu_bus_pkg holds:
  - MemIO encodings MEMIO_NOP=2'b00, MEMIO_RD=2'b01, MEMIO_WR=2'b10, MEMIO_GPR=2'b11.
  - The FSM state typedef for this block.
  - DATA_W default; the ALU moves to these constants later.
- One sub-module, sp_ram: single-port synchronous RAM with we, addr, din and registered dout. No reset on the array.

Test Plan:
- Write then read, WAIT_STATES=2: mem_io=10, addr=0x10, wdata=0xDEADBEEF at E0; then mem_io=01, addr=0x10 at E5. Required: busy high E0..E4; valid_mem_data high only in the cycle after E9; rdata=0xDEADBEEF with rdata_oe=1 in that cycle.
- WAIT_STATES=0 latency: write 0x12345678 to addr 3, then read addr 3. Required: valid_mem_data in the cycle after E2 of the read; rdata=0x12345678.
- Out of range: read with addr=0x400, ADDR_W=10. Required: addr_err pulse in the cycle after E0; valid pulse at normal timing with rdata=0. Also write 0x55 to 0x400. Required: RAM index 0 unchanged.
- Busy drop: read addr 5 at E0, then write to addr 5 at E1. Required: req_drop pulse after E1; RAM[5] unchanged; read completes with the old value.
- Ignored codes: mem_io=11 and 00 for 10 cycles. Required: busy, valid_mem_data, rdata_oe, addr_err and req_drop all stay 0.
- Reset mid-read: assert rst_n=0 during WAIT. Required: all outputs 0 immediately, no valid pulse after release, and the next read of a previously written address returns the stored value.
